// File: rtl/alu_stream_unit.sv
// alu_stream_unit: 8-op ALU behind a valid/ready input and a DEPTH-entry result FIFO (in: in_valid/A/B/F, out: out_valid/R/zero/carry/overflow, count)
module alu_stream_unit #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [WIDTH-1:0]         A,
  input  logic [WIDTH-1:0]         B,
  input  logic [2:0]               F,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [WIDTH-1:0]         R,
  output logic                     zero,
  output logic                     carry,
  output logic                     overflow,
  output logic [$clog2(DEPTH):0]   count
);
  localparam int AW = $clog2(DEPTH);
  logic [WIDTH:0]       w_add, w_sub;
  logic [WIDTH-1:0]     w_res;
  logic                 w_c, w_v, w_add_v, w_sub_v, w_push, w_pop;
  logic [WIDTH-1:0]     r_res [DEPTH];
  logic [DEPTH-1:0]     r_c, r_v;
  logic [AW-1:0]        r_wr, r_rd;
  logic [AW:0]          r_cnt;
  assign w_add   = {1'b0, A} + {1'b0, B};
  assign w_sub   = {1'b0, A} + {1'b0, ~B} + (WIDTH+1)'(1);
  assign w_add_v = (A[WIDTH-1] == B[WIDTH-1]) && (w_add[WIDTH-1] != A[WIDTH-1]);
  assign w_sub_v = (A[WIDTH-1] != B[WIDTH-1]) && (w_sub[WIDTH-1] != A[WIDTH-1]);
  always_comb begin
    w_res = '0;
    w_c   = 1'b0;
    w_v   = 1'b0;
    case (F)
      3'b000: w_res = A & B;
      3'b001: w_res = A | B;
      3'b010: begin
        w_res = w_add[WIDTH-1:0];
        w_c   = w_add[WIDTH];
        w_v   = w_add_v;
      end
      3'b011: w_res = A ^ B;
      3'b100: w_res = A & ~B;
      3'b101: w_res = A | ~B;
      3'b110: begin
        w_res = w_sub[WIDTH-1:0];
        w_c   = w_sub[WIDTH];
        w_v   = w_sub_v;
      end
      3'b111: begin
        w_res = WIDTH'(w_sub[WIDTH-1] ^ w_sub_v);
        w_c   = w_sub[WIDTH];
      end
    endcase
  end
  assign in_ready  = r_cnt != (AW+1)'(DEPTH);
  assign out_valid = r_cnt != '0;
  assign w_push    = in_valid && in_ready;
  assign w_pop     = out_valid && out_ready;
  assign R         = out_valid ? r_res[r_rd] : '0;
  assign zero      = out_valid && (r_res[r_rd] == '0);
  assign carry     = out_valid && r_c[r_rd];
  assign overflow  = out_valid && r_v[r_rd];
  assign count     = r_cnt;
  always_ff @(posedge clk) begin
    if (!rst && w_push) begin
      r_res[r_wr] <= w_res;
      r_c[r_wr]   <= w_c;
      r_v[r_wr]   <= w_v;
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr  <= '0;
      r_rd  <= '0;
      r_cnt <= '0;
    end else begin
      if (w_push) r_wr <= r_wr + 1'b1;
      if (w_pop) r_rd <= r_rd + 1'b1;
      r_cnt <= (w_push && !w_pop) ? r_cnt + 1'b1 : (!w_push && w_pop) ? r_cnt - 1'b1 : r_cnt;
    end
  end
endmodule
